// File: rtl/uart_msg_tx.sv
// uart_msg_tx: frames msg_len bytes from an internal buffer onto a UART line, optionally repeating
// the message with an idle gap. Define UART_MSG_PARITY_EN to add an even-parity bit to every frame.
module uart_msg_tx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int MAX_LEN    = 16,
  parameter int STOP_BITS  = 1,
  parameter int GAP_CYCLES = 10416,
  localparam int LW        = $clog2(MAX_LEN + 1),
  localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [LW-1:0] msg_len,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          stop_req,
  output logic          dout,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] byte_idx
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int TMAX     = (BAUD_DIV > GAP_CYCLES) ? BAUD_DIV : GAP_CYCLES;
  localparam int TW       = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          stop_cnt_reg, stop_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [LW-1:0] idx_reg, idx_next;
  logic [LW-1:0] len_reg, len_next;
  logic          abort_reg, abort_next;
  logic          done_reg, done_next;
  logic [7:0]    buf_reg [MAX_LEN];
  logic          load_byte, bit_end, gap_end, last_stop;
  logic [7:0]    rd_byte;
`ifdef UART_MSG_PARITY_EN
  logic          par_reg, par_next;
`endif

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign byte_idx = idx_reg;

  assign bit_end   = (timer_reg == TW'(BAUD_DIV - 1));
  assign gap_end   = (timer_reg == TW'(GAP_CYCLES - 1));
  assign last_stop = (stop_cnt_reg == 1'(STOP_BITS - 1));
  assign rd_byte   = buf_reg[idx_next[AW-1:0]];

  // Buffer is register-based so reset can preload the ASCII digit pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) buf_reg[i] <= 8'(48 + (i % 10));
    end else if (wr_en && !busy && (int'(wr_addr) < MAX_LEN)) begin
      buf_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + TW'(1);
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    len_next      = len_reg;
    abort_next    = abort_reg;
    done_next     = 1'b0;
    load_byte     = 1'b0;

    // An abort during a frame is remembered so the frame still completes cleanly.
    if (stop_req && (state_reg inside {START, DATA, PARITY, STOP})) abort_next = 1'b1;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        abort_next = 1'b0;
        idx_next   = '0;
        if (start && !stop_req) begin
          if (msg_len == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = START;
            len_next   = (msg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : msg_len;
            load_byte  = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          timer_next   = '0;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_next   = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_MSG_PARITY_EN
            state_next    = PARITY;
`else
            state_next    = STOP;
`endif
            stop_cnt_next = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          timer_next    = '0;
          stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_next = '0;
          if (!last_stop) begin
            stop_cnt_next = 1'b1;
          end else if (abort_reg || stop_req) begin
            state_next = IDLE;
            idx_next   = '0;
          end else if (idx_reg == len_reg - LW'(1)) begin
            done_next  = 1'b1;
            idx_next   = '0;
            state_next = repeat_en ? GAP : IDLE;
          end else begin
            idx_next   = idx_reg + LW'(1);
            state_next = START;
            load_byte  = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop_req) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (gap_end) begin
          state_next = START;
          timer_next = '0;
          idx_next   = '0;
          load_byte  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    if (load_byte) shift_next = rd_byte;
  end

`ifdef UART_MSG_PARITY_EN
  always_comb begin
    par_next = par_reg;
    if (load_byte) par_next = ^rd_byte;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      idx_reg      <= '0;
      len_reg      <= '0;
      abort_reg    <= 1'b0;
      done_reg     <= 1'b0;
`ifdef UART_MSG_PARITY_EN
      par_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      len_reg      <= len_next;
      abort_reg    <= abort_next;
      done_reg     <= done_next;
`ifdef UART_MSG_PARITY_EN
      par_reg      <= par_next;
`endif
    end
  end

  // Line decode straight from state so an asynchronous reset raises dout immediately.
  always_comb begin
    dout = 1'b1;
    case (state_reg)
      START:   dout = 1'b0;
      DATA:    dout = shift_reg[0];
`ifdef UART_MSG_PARITY_EN
      PARITY:  dout = par_reg;
`endif
      default: dout = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Scoreboard bench for uart_msg_tx: stimulus queues expected bytes, a line monitor decodes frames
// from dout and compares; timing of done/busy is checked against hand-computed cycle counts.
module tb_uart_msg_tx;
  localparam int BD = 16;
`ifdef UART_MSG_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FR      = BD * (10 + PBITS);
  localparam int PAR_AT  = (PBITS != 0) ? BD * 9 + 8 : -1;
  localparam int STOP_AT = BD * (9 + PBITS) + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] msg_len = '0;
  logic       start = 1'b0;
  logic       repeat_en = 1'b0;
  logic       stop_req = 1'b0;
  logic       dout, busy, done;
  logic [4:0] byte_idx;

  uart_msg_tx #(.CLK_HZ(16), .BAUD(1), .MAX_LEN(16), .STOP_BITS(1), .GAP_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .repeat_en(repeat_en), .stop_req(stop_req),
    .dout(dout), .busy(busy), .done(done), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int frame_starts[$];
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line monitor: samples mid-bit, reconstructs each frame, then pops the scoreboard.
  int rx_state = 0;
  int rx_cnt = 0;
  logic [7:0] rx_byte;
  logic rx_start_ok, rx_par;
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_state = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (rx_state == 0) begin
        if (dout === 1'b0) begin
          rx_state = 1; rx_cnt = 0; rx_start_ok = 1'b1; rx_par = 1'b0;
          frame_starts.push_back(cyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 8) begin
          if (dout !== 1'b0) rx_start_ok = 1'b0;
        end else if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt % 16) == 8) begin
          rx_byte[(rx_cnt - 24) / 16] = dout;
        end else if (rx_cnt == PAR_AT) begin
          rx_par = dout;
        end else if (rx_cnt == STOP_AT) begin
          rx_state = 0;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame actual=%02h required=no frame (cycle %0d)", rx_byte, cyc);
          end else begin
            rx_exp = exp_q.pop_front();
            chk("frame_byte", 32'(rx_byte), 32'(rx_exp));
            chk("frame_start_bit", 32'(rx_start_ok), 32'd1);
            chk("frame_stop_bit", 32'(dout), 32'd1);
            if (PBITS != 0) chk("frame_parity", 32'(rx_par), 32'(^rx_exp));
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic start_msg(input logic [4:0] len, output int acc);
    @(negedge clk); msg_len = len; start = 1'b1;
    @(negedge clk); start = 1'b0; acc = cyc;
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) at = cyc;
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none required=done within %0d cycles", bound);
    end
  endtask

  task automatic wait_idle(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) at = cyc;
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", bound);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, d, d2, t, dc;
    $display("tb_uart_msg_tx: frame length %0d clocks", FR);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two bytes from the reset buffer: "0","1"
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    start_msg(5'd2, a);
    $display("txn: msg_len=2 accepted at %0d", a);
    chk("first_start_low", 32'(dout), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("byte_idx_first", 32'(byte_idx), 32'd0);
    goto(a + FR + 8);
    chk("byte_idx_second", 32'(byte_idx), 32'd1);
    wait_done(3 * FR, d);
    chk("done_at_2frames", 32'(d - a), 32'(2 * FR));
    chk("busy_falls_with_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("byte_idx_back_to_0", 32'(byte_idx), 32'd0);

    // Written byte 0xA5: bits 1,0,1,0,0,1,0,1 LSB first, even parity 0
    write_byte(4'd0, 8'hA5);
    exp_q.push_back(8'hA5);
    start_msg(5'd1, a);
    $display("txn: write A5, msg_len=1 accepted at %0d", a);
    wait_done(2 * FR, d);
    chk("done_at_1frame", 32'(d - a), 32'(FR));

    // msg_len 20 clamps to 16 bytes
    for (int i = 0; i < 16; i++) exp_q.push_back((i == 0) ? 8'hA5 : 8'(8'h30 + i % 10));
    start_msg(5'd20, a);
    $display("txn: msg_len=20 (clamped) accepted at %0d", a);
    goto(a + 15 * FR + 8);
    chk("byte_idx_last", 32'(byte_idx), 32'd15);
    wait_done(17 * FR, d);
    chk("done_at_16frames", 32'(d - a), 32'(16 * FR));
    repeat (3) @(negedge clk);

    // Repeat mode with a 5-clock gap, then abort inside the gap
    frame_starts.delete();
    repeat_en = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    start_msg(5'd1, a);
    $display("txn: repeat msg_len=1 accepted at %0d", a);
    wait_done(2 * FR, d);
    chk("repeat_first_done", 32'(d - a), 32'(FR));
    wait_done(2 * FR, d2);
    chk("repeat_period", 32'(d2 - d), 32'(FR + 5));
    stop_req = 1'b1; repeat_en = 1'b0;
    @(negedge clk); stop_req = 1'b0;
    chk("gap_abort_busy", 32'(busy), 32'd0);
    chk("gap_abort_dout", 32'(dout), 32'd1);
    repeat (2 * FR) @(negedge clk);
    chk("repeat_frame_count", 32'(frame_starts.size()), 32'd2);
    if (frame_starts.size() >= 2) chk("repeat_frame_spacing", 32'(frame_starts[1] - frame_starts[0]), 32'(FR + 5));

    // stop_req at clock 40 of a 3-byte message
    dc = done_cnt;
    exp_q.push_back(8'hA5);
    start_msg(5'd3, a);
    $display("txn: msg_len=3 with stop_req at +40, accepted at %0d", a);
    goto(a + 40); stop_req = 1'b1;
    @(negedge clk); stop_req = 1'b0;
    wait_idle(3 * FR, t);
    chk("abort_idle_at", 32'(t - a), 32'(FR));
    repeat (FR) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));

    // msg_len = 0: no frame, done one cycle later, busy stays low
    frame_starts.delete();
    start_msg(5'd0, a);
    $display("txn: msg_len=0 accepted at %0d", a);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_dout", 32'(dout), 32'd1);
    @(negedge clk);
    chk("len0_done_pulse", 32'(done), 32'd0);

    // start together with stop_req in IDLE is ignored
    @(negedge clk); msg_len = 5'd1; start = 1'b1; stop_req = 1'b1;
    @(negedge clk); start = 1'b0; stop_req = 1'b0;
    $display("txn: start+stop_req in idle at %0d", cyc);
    chk("start_stop_ignored", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("no_frame_idle_cases", 32'(frame_starts.size()), 32'd0);

    // start and wr_en while busy are ignored
    exp_q.push_back(8'hA5);
    start_msg(5'd1, a);
    $display("txn: busy start/write attempt, accepted at %0d", a);
    goto(a + 20);
    msg_len = 5'd3; start = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hEE;
    @(negedge clk); start = 1'b0; wr_en = 1'b0;
    wait_done(2 * FR, d);
    chk("busy_start_ignored", 32'(d - a), 32'(FR));
    exp_q.push_back(8'hA5); exp_q.push_back(8'h31);
    start_msg(5'd2, a);
    $display("txn: readback msg_len=2 accepted at %0d", a);
    wait_done(3 * FR, d);
    chk("readback_done", 32'(d - a), 32'(2 * FR));

    // Reset in the middle of a frame, then a fresh full frame
    exp_q.push_back(8'h31);
    start_msg(5'd2, a);
    $display("txn: reset at +50, accepted at %0d", a);
    goto(a + 50);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_dout", 32'(dout), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_byte_idx", 32'(byte_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h30);
    start_msg(5'd1, a);
    $display("txn: post-reset msg_len=1 accepted at %0d", a);
    goto(a + BD - 1);
    chk("post_rst_start_bit_end", 32'(dout), 32'd0);
    wait_done(2 * FR, d);
    chk("post_rst_done", 32'(d - a), 32'(FR));

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_msg_tx.md
UART_MSG_TX -- requirements
Module: uart_msg_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: line bit rate; BAUD_DIV = CLK_HZ/BAUD (integer truncation) clocks per bit.
REQ-003 Parameter MAX_LEN, default 16: message buffer depth in bytes; LW = clog2(MAX_LEN+1).
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 Parameter GAP_CYCLES, default 10416: idle-high clocks between message repeats; legal range >= 1.
REQ-006 clk  input  1  the single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  buffer write strobe.
REQ-009 wr_addr  input  clog2(MAX_LEN)  write address.
REQ-010 wr_data  input  8  write byte.
REQ-011 msg_len  input  LW  number of bytes to send; sampled on accepted start.
REQ-012 start  input  1  one-cycle send request.
REQ-013 repeat_en  input  1  1 = resend the message continuously; sampled at each message end.
REQ-014 stop_req  input  1  abort request.
REQ-015 dout  output  1  serial line, idle high.
REQ-016 busy  output  1  high from start acceptance until return to IDLE.
REQ-017 done  output  1  one-cycle pulse at each completed message.
REQ-018 byte_idx  output  LW  index of the byte currently framed.

Function
REQ-019 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and GAP; each bit state SHALL hold dout for exactly BAUD_DIV clocks, counted by a bit-timer that restarts at every state entry.
REQ-020 A start SHALL be accepted only in IDLE; start while busy SHALL be ignored; dout SHALL fall low the cycle after acceptance.
REQ-021 Frame order SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-034), STOP_BITS stop bits at 1.
REQ-022 Each byte SHALL be read from buffer[byte_idx] on START entry; bytes SHALL go back-to-back with no idle gap.
REQ-023 After the last stop bit of byte msg_len-1, done SHALL pulse for one cycle; then, if repeat_en=1, the FSM SHALL enter GAP (dout=1) for GAP_CYCLES clocks and restart at byte 0, else it SHALL enter IDLE.
REQ-024 Accepted start with msg_len=0 SHALL send no frame, pulse done one cycle later, and leave busy low.
REQ-025 msg_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-026 stop_req during a frame SHALL let the current frame finish, then go to IDLE without done; stop_req in GAP SHALL go to IDLE next cycle; stop_req and start together in IDLE SHALL ignore the start.
REQ-027 Writes SHALL be accepted only while busy=0; wr_addr >= MAX_LEN SHALL be ignored.
REQ-028 byte_idx SHALL advance at START entry of each next byte and return to 0 at message end.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, dout=1, busy=0, done=0, byte_idx=0, with all timers cleared.
REQ-030 Reset SHALL load buffer[i] = 0x30 + (i mod 10), i.e. ASCII "0123456789012345" for default MAX_LEN.
REQ-031 Reset asserted mid-frame SHALL truncate the frame; the line SHALL be high the same instant.
REQ-032 After release, the first accepted start SHALL produce a full-length start bit.

Configuration
REQ-033 Macro UART_MSG_PARITY_EN SHALL select parity generation.
REQ-034 With UART_MSG_PARITY_EN defined, PARITY SHALL follow DATA and send even parity (XOR of the 8 data bits); without it, PARITY SHALL be skipped and frames SHALL be 9+STOP_BITS bits long.

Verification
REQ-035 CLK_HZ=16, BAUD=1, no parity, reset buffer, msg_len=2, start -> dout bits 0,0x30 LSB-first,1,0,0x31,1, each 16 clocks; done pulses once at clock 320; busy falls.
REQ-036 Write 0xA5 at addr 0, msg_len=1, parity build -> frame 0,1,0,1,0,0,1,0,1,0(parity),1; without macro parity bit absent.
REQ-037 repeat_en=1, GAP_CYCLES=5, msg_len=1 -> done every 160+5 clocks, dout high exactly 5 clocks between frames.
REQ-038 stop_req at clock 40 of a 3-byte message -> first frame completes at clock 160, then IDLE, no done.
REQ-039 msg_len=0 start -> no low on dout, done one cycle later; start during busy and wr_en during busy -> ignored, buffer unchanged.
REQ-040 rst_n low at clock 50 of a frame -> dout=1 and busy=0 immediately; new start sends a full 16-clock start bit.
